// File: rtl/signed_calc_pkg.sv
// signed_calc_pkg -- shared definitions for the sequential sign-magnitude divider.
//   state_t        : divider FSM states (IDLE, CALC, DONE)
//   DEFAULT_WIDTH  : default sign-magnitude operand width
//   sign_idx()     : bit index of the sign bit for a given width
//   mag_msb()      : bit index of the magnitude MSB for a given width
package signed_calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 3;

  function automatic int sign_idx(input int width);
    return width - 1;
  endfunction

  function automatic int mag_msb(input int width);
    return width - 2;
  endfunction

endpackage

// File: rtl/signed_divider_seq_if.sv
// signed_divider_seq_if -- request/result bundle for signed_divider_seq.
//   start, a, b        : request side, driven by the master
//   busy, done         : status, driven by the divider
//   quotient, remainder: registered sign-magnitude results
//   div_zero           : divisor-magnitude-zero flag (only with DIV_ZERO_FLAG_EN)
//   state_dbg          : current FSM state, for observation only
//
// Handshake: start is a request that the divider takes on a rising edge only
// when busy=0 and done=0 (the IDLE cycle after a done pulse is the earliest
// reissue point). a and b are sampled on that same edge only. done is a
// one-cycle pulse; quotient/remainder (and div_zero) are valid from that
// cycle and hold until the next accepted request completes.
interface signed_divider_seq_if
  import signed_calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_zero;
`endif
  state_t           state_dbg;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, state_dbg
`ifdef DIV_ZERO_FLAG_EN
    , input div_zero
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, state_dbg
`ifdef DIV_ZERO_FLAG_EN
    , output div_zero
`endif
  );

endinterface

// File: rtl/signed_divider_seq_div_step.sv
// div_step -- one unsigned restoring-division step (combinational).
//   rem_in       : partial remainder before the step (M bits)
//   dividend_bit : next dividend magnitude bit, MSB first
//   divisor      : divisor magnitude (M bits)
//   rem_out      : partial remainder after the step
//   q_bit        : quotient bit produced by this step
// The shifted remainder and the subtraction are M+1 bits wide so the
// compare/subtract never overflows. With a zero divisor every step
// "succeeds", giving an all-ones quotient and a remainder equal to the
// dividend, which is exactly the divide-by-zero result we want.
module div_step #(
  parameter int M = 2
) (
  input  logic [M-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [M-1:0] divisor,
  output logic [M-1:0] rem_out,
  output logic         q_bit
);

  logic [M:0] shifted;
  logic [M:0] diff;

  assign shifted = {rem_in, dividend_bit};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign diff    = shifted - {1'b0, divisor};
  // Result always fits in M bits: below the divisor when it is non-zero,
  // or a prefix of the M-bit dividend when the divisor is zero.
  assign rem_out = M'(q_bit ? diff : shifted);

endmodule

// File: rtl/signed_divider_seq.sv
// signed_divider_seq -- sequential sign-magnitude divider, one quotient bit
// per clock (restoring division on the magnitudes, MSB first).
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : signed_divider_seq_if.slave (start/a/b in; busy/done/
//                quotient/remainder/state_dbg out; div_zero when enabled)
// Optional feature: define DIV_ZERO_FLAG_EN to build the registered
// div_zero flag (1 iff the latched divisor magnitude is zero).
// Timing: request taken at edge A; steps run on edges A+1..A+M; results and
// done register on edge A+M+1. busy is high from edge A to edge A+M+1.
// WIDTH must be at least 3.
module signed_divider_seq
  import signed_calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst_n,
  signed_divider_seq_if.slave bus
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);
  localparam int SI = sign_idx(WIDTH);
  localparam int MM = mag_msb(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    cnt;
  logic             a_sign;
  logic             b_sign;
  logic [M-1:0]     dvd;
  logic [M-1:0]     dvs;
  logic [M-1:0]     rem;
  logic [M-1:0]     q_acc;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             done_r;
  logic [M-1:0]     step_rem;
  logic             step_q;
  logic             accept;
  logic             q_sign;

  // done_r is high only in the IDLE cycle right after DONE; gating on it
  // keeps a start that coincides with the done pulse from being taken.
  assign accept = (state == IDLE) && bus.start && !done_r;

  // Negative zero is not produced for the quotient.
  assign q_sign = (a_sign ^ b_sign) && (q_acc != '0);

  div_step #(.M(M)) u_step (
    .rem_in       (rem),
    .dividend_bit (dvd[MM]),
    .divisor      (dvs),
    .rem_out      (step_rem),
    .q_bit        (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (cnt == CW'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      a_sign      <= 1'b0;
      b_sign      <= 1'b0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      q_acc       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= (state == DONE);
      if (accept) begin
        a_sign <= bus.a[SI];
        b_sign <= bus.b[SI];
        dvd    <= bus.a[MM:0];
        dvs    <= bus.b[MM:0];
        rem    <= '0;
        q_acc  <= '0;
        cnt    <= CW'(M);
      end else if (state == CALC) begin
        rem   <= step_rem;
        q_acc <= {q_acc[MM-1:0], step_q};
        dvd   <= {dvd[MM-1:0], 1'b0};
        cnt   <= cnt - CW'(1);
      end else if (state == DONE) begin
        quotient_r  <= {q_sign, q_acc};
        // Remainder keeps the dividend sign, including negative zero.
        remainder_r <= {a_sign, rem};
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic div_zero_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              div_zero_r <= 1'b0;
    else if (state == DONE)  div_zero_r <= (dvs == '0);
  end

  assign bus.div_zero = div_zero_r;
`endif

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_signed_divider_seq.sv
// tb_signed_divider_seq -- directed + random bench for signed_divider_seq
// (WIDTH=3). Expected results come from an arithmetic model using / and %,
// are queued when a request is driven and popped when done pulses.
// Works with or without DIV_ZERO_FLAG_EN.
module tb_signed_divider_seq;
  import signed_calc_pkg::*;

  localparam int W  = 3;
  localparam int M  = W - 1;
  localparam int EW = 2 * W + 1;

  logic clk;
  logic rst_n;

  signed_divider_seq_if #(.WIDTH(W)) bus ();

  signed_divider_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // {div_zero, quotient, remainder}
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [M-1:0] am, bm, qm, rm;
    logic as, bs, qs, dz;
    am = a[M-1:0];
    bm = b[M-1:0];
    as = a[W-1];
    bs = b[W-1];
    dz = (bm == 0);
    if (dz) begin
      qm = '1;
      rm = am;
    end else begin
      qm = am / bm;
      rm = am % bm;
    end
    qs = (as ^ bs) && (qm != 0);
`ifndef DIV_ZERO_FLAG_EN
    dz = 1'b0;
`endif
    return {dz, qs, qm, as, rm};
  endfunction

  function automatic logic [EW-1:0] observed();
    logic dz;
`ifdef DIV_ZERO_FLAG_EN
    dz = bus.div_zero;
`else
    dz = 1'b0;
`endif
    return {dz, bus.quotient, bus.remainder};
  endfunction

  // Drive one request and follow it to done. inject: pulse a second start
  // during CALC. retry_on_done: hold start high through the done cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject, input bit retry_on_done);
    int lat;
    logic [EW-1:0] exp;
    logic [EW-1:0] held;
    exp_q.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (inject && k == 2) begin
        bus.start = 1'b1;
        bus.a = 3'b010;
        bus.b = 3'b010;
      end
      if (inject && k == 3) bus.start = 1'b0;
      if (bus.done) begin
        lat = k - 1;
        break;
      end
      check("busy_during_op", bus.busy, 1'b1);
    end
    check("latency_edges", lat, M + 1);
    check("busy_in_done_cycle", bus.busy, 1'b0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("result", observed(), exp);
    end else begin
      check("scoreboard_underflow", exp_q.size(), 1);
    end
    held = observed();
    if (retry_on_done) begin
      bus.start = 1'b1;
      bus.a = 3'b001;
      bus.b = 3'b001;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", bus.done, 1'b0);
    check("results_hold", observed(), held);
    if (retry_on_done) check("start_in_done_ignored", bus.busy, 1'b0);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (bus.done) n++;
    end
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_quotient", bus.quotient, 3'b000);
    check("rst_remainder", bus.remainder, 3'b000);
    check("rst_state", bus.state_dbg, IDLE);
`ifdef DIV_ZERO_FLAG_EN
    check("rst_div_zero", bus.div_zero, 1'b0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // basic, with a start held through the done cycle
    run_op(3'b011, 3'b010, 1'b0, 1'b1);
    check("v029_q", bus.quotient, 3'b001);
    check("v029_r", bus.remainder, 3'b001);

    run_op(3'b111, 3'b001, 1'b0, 1'b0);
    check("v030_q", bus.quotient, 3'b111);
    check("v030_r", bus.remainder, 3'b100);

    run_op(3'b110, 3'b110, 1'b0, 1'b0);
    check("v031a_q", bus.quotient, 3'b001);
    check("v031a_r", bus.remainder, 3'b100);

    run_op(3'b001, 3'b110, 1'b0, 1'b0);
    check("v031b_q", bus.quotient, 3'b000);
    check("v031b_r", bus.remainder, 3'b001);

    run_op(3'b010, 3'b100, 1'b0, 1'b0);
    check("v032_q", bus.quotient, 3'b111);
    check("v032_r", bus.remainder, 3'b010);
`ifdef DIV_ZERO_FLAG_EN
    check("v032_dz", bus.div_zero, 1'b1);
`endif

    // second start during CALC must be ignored
    run_op(3'b011, 3'b001, 1'b1, 1'b0);
    check("v033_q", bus.quotient, 3'b011);
    check("v033_r", bus.remainder, 3'b000);
    count_dones(8, nd);
    check("v033_single_done", nd, 0);

    // reset in the first CALC cycle aborts the divide
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 3'b011;
    bus.b = 3'b010;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_quotient", bus.quotient, 3'b000);
    check("abort_remainder", bus.remainder, 3'b000);
    check("abort_state", bus.state_dbg, IDLE);
`ifdef DIV_ZERO_FLAG_EN
    check("abort_div_zero", bus.div_zero, 1'b0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(6, nd);
    check("abort_no_done", nd, 0);
    run_op(3'b011, 3'b010, 1'b0, 1'b0);
    check("v034_q", bus.quotient, 3'b001);
    check("v034_r", bus.remainder, 3'b001);

    // random operands
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom_range(0, 7)), W'($urandom_range(0, 7)), 1'b0, 1'b0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signed_divider_seq.md
SIGNED_DIVIDER_SEQ -- requirements
Module: signed_divider_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter WIDTH, default 3, SHALL set the sign-magnitude operand width: bit WIDTH-1 is the sign, bits WIDTH-2:0 are the magnitude.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a divide; accepted only when busy=0.
REQ-006 a  input  WIDTH  dividend, sign-magnitude.
REQ-007 b  input  WIDTH  divisor, sign-magnitude.
REQ-008 busy  output  1  high while a divide is in progress.
REQ-009 done  output  1  one-cycle pulse when quotient and remainder are valid.
REQ-010 quotient  output  WIDTH  registered sign-magnitude quotient.
REQ-011 remainder  output  WIDTH  registered sign-magnitude remainder; this feeds the downstream remainder/result stage.
REQ-012 div_zero  output  1  divisor-magnitude-zero flag; the port exists only when DIV_ZERO_FLAG_EN is defined.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
  - IDLE->CALC on start.
  - CALC->DONE after M=WIDTH-1 iterations.
  - DONE->IDLE after one cycle.
REQ-014 On an accepted start, the block SHALL latch a and b, clear the partial remainder, load an iteration counter with M, and assert busy from the next cycle.
REQ-015 CALC SHALL perform one unsigned restoring-division step per cycle on the magnitudes, MSB first.
  - Each step shifts in the next dividend bit and subtracts the divisor when the result is non-negative.
  - Each step produces one quotient bit.
  - Intermediate arithmetic SHALL be M+1 bits wide, so the subtraction cannot overflow.
REQ-016 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge M+1 (cycle 3 for WIDTH=3); busy SHALL be high from edge 1 through edge M+1.
REQ-017 In DONE, quotient and remainder SHALL update, done SHALL pulse for exactly one cycle, and busy SHALL fall at the next edge.
REQ-018 The outputs SHALL hold until the next accepted start completes.
REQ-019 Quotient sign SHALL be a_sign XOR b_sign, forced to 0 when the quotient magnitude is zero.
REQ-020 Remainder sign SHALL equal a_sign, even when the remainder magnitude is zero, to match the downstream remainder convention.
REQ-021 A divisor magnitude of zero SHALL give a quotient magnitude of all ones with sign per REQ-019, and a remainder equal to the latched dividend; latency is unchanged.
REQ-022 start while busy=1 (CALC or DONE) SHALL be ignored; the latched operands SHALL NOT change.
REQ-023 start asserted in the same cycle that done is high SHALL be ignored; a new start is accepted from the following IDLE cycle.

Reset
REQ-024 rst_n low SHALL immediately force the following, regardless of state:
  - state=IDLE, busy=0, done=0;
  - quotient=0, remainder=0, div_zero=0;
  - counter and operand registers cleared.
REQ-025 A reset asserted mid-CALC SHALL abort the divide with no done pulse; the first start after rst_n deasserts SHALL be processed normally.

Configuration
REQ-026 Macro DIV_ZERO_FLAG_EN compiles the divide-by-zero flag in or out.
  - Defined: div_zero is registered and updates together with quotient/remainder in DONE; it is 1 iff the latched divisor magnitude is 0, and is held like the results.
  - Undefined: the div_zero port and its logic are absent; all other behaviour is identical.

Structure
REQ-027 Shared package signed_calc_pkg SHALL hold:
  - the FSM state enum (IDLE, CALC, DONE);
  - the default operand width constant (3);
  - sign-bit index helpers.
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.

Verification (WIDTH=3)
REQ-029 a=011, b=010, start -> done in cycle 3, quotient=001, remainder=001.
REQ-030 a=111, b=001 -> quotient=111, remainder=100 (negative-zero remainder preserved).
REQ-031 a=110, b=110 -> quotient=001, remainder=100; a=001, b=110 -> quotient=000, remainder=001.
REQ-032 a=010, b=100 -> quotient=111, remainder=010, div_zero=1 with the macro defined; the same quotient and remainder with no div_zero port when undefined.
REQ-033 start with a=011, b=001, then start pulsed again with a=010, b=010 during CALC -> only one done, with quotient=011, remainder=000.
REQ-034 rst_n low at CALC cycle 1 -> no done pulse and all outputs 0; a subsequent start with a=011, b=010 completes per REQ-029.
